// File: rtl/sdmac_fifo.sv
// SDMAC longword FIFO: 8 x 32-bit entries, byte-lane access from the SCSI side,
// longword access from the bus side, pointer/count movement driven by external strobes.
module sdmac_fifo #(
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  CPUCLK,
   input  logic                  RESET_,
   input  logic                  FIFO_CLR,
   input  logic                  INCFIFO,
   input  logic                  DECFIFO,
   input  logic                  INCNI,
   input  logic                  INCNO,
   input  logic                  INCBO,
   input  logic                  S2F,
   input  logic                  LW_WR,
   input  logic [7:0]            SCSI_DIN,
   input  logic [31:0]           BUS_DIN,
   output logic [31:0]           BUS_DOUT,
   output logic [7:0]            SCSI_DOUT,
   output logic [1:0]            BO,
   output logic [DEPTH_LOG2-1:0] NI,
   output logic [DEPTH_LOG2-1:0] NO,
   output logic [DEPTH_LOG2:0]   FIFOCNT,
   output logic                  FIFOFULL,
   output logic                  FIFOEMPTY,
   output logic                  BOEQ3,
   output logic                  OVF,
   output logic                  UNF
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [31:0] mem [DEPTH];

   // Big-endian lanes: BO=0 selects [31:24], so the lane base bit is (3-BO)*8 == {~BO,3'b000}.
   always_ff @(posedge CPUCLK) begin
      if (!RESET_) begin
         mem <= '{default: '0};
      end else if (!FIFO_CLR) begin
         if (LW_WR) begin
            mem[NI] <= BUS_DIN;
         end else if (S2F) begin
            mem[NI][{~BO, 3'b000} +: 8] <= SCSI_DIN;
         end
      end
   end

   always_ff @(posedge CPUCLK) begin
      if (!RESET_ || FIFO_CLR) begin
         BO      <= '0;
         NI      <= '0;
         NO      <= '0;
         FIFOCNT <= '0;
         OVF     <= 1'b0;
         UNF     <= 1'b0;
      end else begin
         if (INCBO) BO <= BO + 2'd1;
         if (INCNI) NI <= NI + PTR_ONE;
         if (INCNO) NO <= NO + PTR_ONE;
         // Simultaneous INCFIFO/DECFIFO cancel; saturation only flags misuse.
         case ({INCFIFO, DECFIFO})
            2'b10: begin
               if (FIFOFULL) OVF <= 1'b1;
               else          FIFOCNT <= FIFOCNT + CNT_ONE;
            end
            2'b01: begin
               if (FIFOEMPTY) UNF <= 1'b1;
               else           FIFOCNT <= FIFOCNT - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   assign FIFOFULL  = (FIFOCNT == CNT_FULL);
   assign FIFOEMPTY = (FIFOCNT == '0);
   assign BOEQ3     = (BO == 2'd3);
   assign BUS_DOUT  = mem[NO];
   assign SCSI_DOUT = mem[NO][{~BO, 3'b000} +: 8];

endmodule

// File: tb/tb_sdmac_fifo.sv
// Bench for sdmac_fifo: directed test-plan sequences with literal expectations,
// then randomized strobes checked every cycle against an arithmetic reference model.
module tb_sdmac_fifo;

   logic        CPUCLK = 1'b0;
   logic        RESET_, FIFO_CLR, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, S2F, LW_WR;
   logic [7:0]  SCSI_DIN;
   logic [31:0] BUS_DIN;
   logic [31:0] BUS_DOUT;
   logic [7:0]  SCSI_DOUT;
   logic [1:0]  BO;
   logic [2:0]  NI, NO;
   logic [3:0]  FIFOCNT;
   logic        FIFOFULL, FIFOEMPTY, BOEQ3, OVF, UNF;

   sdmac_fifo #(.DEPTH_LOG2(3)) dut (
      .CPUCLK(CPUCLK), .RESET_(RESET_), .FIFO_CLR(FIFO_CLR),
      .INCFIFO(INCFIFO), .DECFIFO(DECFIFO), .INCNI(INCNI), .INCNO(INCNO),
      .INCBO(INCBO), .S2F(S2F), .LW_WR(LW_WR),
      .SCSI_DIN(SCSI_DIN), .BUS_DIN(BUS_DIN),
      .BUS_DOUT(BUS_DOUT), .SCSI_DOUT(SCSI_DOUT), .BO(BO), .NI(NI), .NO(NO),
      .FIFOCNT(FIFOCNT), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
      .BOEQ3(BOEQ3), .OVF(OVF), .UNF(UNF)
   );

   initial forever #5 CPUCLK = ~CPUCLK;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   // Reference model: plain integers and an array of longwords.
   logic [31:0] m_mem [8];
   int unsigned m_bo, m_ni, m_no, m_cnt;
   bit          m_ovf, m_unf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_tick();
      int unsigned sh;
      if (!RESET_) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
         m_bo = 0; m_ni = 0; m_no = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (FIFO_CLR) begin
         m_bo = 0; m_ni = 0; m_no = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         if (LW_WR) begin
            m_mem[3'(m_ni)] = BUS_DIN;
         end else if (S2F) begin
            sh = 8 * (3 - m_bo);
            m_mem[3'(m_ni)] = (m_mem[3'(m_ni)] & ~(32'hFF << sh)) | (32'(SCSI_DIN) << sh);
         end
         if (INCBO) m_bo = (m_bo + 1) % 4;
         if (INCNI) m_ni = (m_ni + 1) % 8;
         if (INCNO) m_no = (m_no + 1) % 8;
         if (INCFIFO && !DECFIFO) begin
            if (m_cnt == 8) m_ovf = 1'b1;
            else            m_cnt = m_cnt + 1;
         end else if (DECFIFO && !INCFIFO) begin
            if (m_cnt == 0) m_unf = 1'b1;
            else            m_cnt = m_cnt - 1;
         end
      end
   endtask

   always @(negedge CPUCLK) begin
      if (chk_on) begin
         chk("BUS_DOUT",  BUS_DOUT, m_mem[3'(m_no)]);
         chk("SCSI_DOUT", 32'(SCSI_DOUT), (m_mem[3'(m_no)] >> (8 * (3 - m_bo))) & 32'hFF);
         chk("BO",        32'(BO), m_bo);
         chk("NI",        32'(NI), m_ni);
         chk("NO",        32'(NO), m_no);
         chk("FIFOCNT",   32'(FIFOCNT), m_cnt);
         chk("FIFOFULL",  32'(FIFOFULL), 32'(m_cnt == 8));
         chk("FIFOEMPTY", 32'(FIFOEMPTY), 32'(m_cnt == 0));
         chk("BOEQ3",     32'(BOEQ3), 32'(m_bo == 3));
         chk("OVF",       32'(OVF), 32'(m_ovf));
         chk("UNF",       32'(UNF), 32'(m_unf));
      end
   end

   task automatic idle();
      RESET_ = 1'b1; FIFO_CLR = 1'b0; INCFIFO = 1'b0; DECFIFO = 1'b0;
      INCNI = 1'b0; INCNO = 1'b0; INCBO = 1'b0; S2F = 1'b0; LW_WR = 1'b0;
   endtask

   task automatic step();
      @(posedge CPUCLK);
      model_tick();
      @(negedge CPUCLK);
   endtask

   task automatic flush();
      idle(); FIFO_CLR = 1'b1; step();
   endtask

   logic [7:0]  exp_b [4];
   logic [31:0] exp_w;

   initial begin
      idle();
      SCSI_DIN = 8'h5A;
      BUS_DIN  = 32'hDEADBEEF;
      @(negedge CPUCLK);

      // Reset held two cycles with every strobe high.
      RESET_ = 1'b0; FIFO_CLR = 1'b1; INCFIFO = 1'b1; DECFIFO = 1'b1;
      INCNI = 1'b1; INCNO = 1'b1; INCBO = 1'b1; S2F = 1'b1; LW_WR = 1'b1;
      step(); step();
      chk_on = 1'b1;
      chk("rst_BO", 32'(BO), 32'd0);
      chk("rst_NI", 32'(NI), 32'd0);
      chk("rst_NO", 32'(NO), 32'd0);
      chk("rst_CNT", 32'(FIFOCNT), 32'd0);
      chk("rst_EMPTY", 32'(FIFOEMPTY), 32'd1);
      chk("rst_FULL", 32'(FIFOFULL), 32'd0);
      chk("rst_BOEQ3", 32'(BOEQ3), 32'd0);
      chk("rst_BUS_DOUT", BUS_DOUT, 32'h0);

      // SCSI-to-FIFO packing of bytes 0x00..0x1F.
      for (int i = 0; i < 32; i++) begin
         idle();
         S2F = 1'b1; INCBO = 1'b1; SCSI_DIN = 8'(i);
         INCNI = (i % 4 == 3); INCFIFO = (i % 4 == 3);
         step();
      end
      chk("pack_NI", 32'(NI), 32'd0);
      chk("pack_CNT", 32'(FIFOCNT), 32'd8);
      chk("pack_FULL", 32'(FIFOFULL), 32'd1);
      chk("pack_BO", 32'(BO), 32'd0);

      // Drain to bus.
      for (int i = 0; i < 8; i++) begin
         exp_w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
         chk("drain_BUS_DOUT", BUS_DOUT, exp_w);
         idle(); INCNO = 1'b1; DECFIFO = 1'b1;
         step();
      end
      chk("drain_CNT", 32'(FIFOCNT), 32'd0);
      chk("drain_EMPTY", 32'(FIFOEMPTY), 32'd1);
      chk("drain_NO", 32'(NO), 32'd0);
      chk("drain_UNF", 32'(UNF), 32'd0);

      // Bus-to-SCSI byte unpacking.
      idle(); LW_WR = 1'b1; BUS_DIN = 32'hA1B2C3D4; INCNI = 1'b1; INCFIFO = 1'b1;
      step();
      exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      for (int k = 0; k < 4; k++) begin
         chk("unpack_SCSI_DOUT", 32'(SCSI_DOUT), 32'(exp_b[k]));
         chk("unpack_BOEQ3", 32'(BOEQ3), 32'(k == 3));
         idle(); INCBO = 1'b1;
         step();
      end
      chk("unpack_BO", 32'(BO), 32'd0);

      // Overflow at count 8.
      idle(); INCFIFO = 1'b1;
      repeat (7) step();
      chk("ovf_CNT_pre", 32'(FIFOCNT), 32'd8);
      step();
      chk("ovf_CNT", 32'(FIFOCNT), 32'd8);
      chk("ovf_OVF", 32'(OVF), 32'd1);
      idle(); step();
      chk("ovf_sticky", 32'(OVF), 32'd1);
      flush();
      chk("clr_OVF", 32'(OVF), 32'd0);

      // Underflow at count 0.
      idle(); DECFIFO = 1'b1; step();
      chk("unf_UNF", 32'(UNF), 32'd1);
      chk("unf_CNT", 32'(FIFOCNT), 32'd0);
      flush();

      // INCFIFO+DECFIFO together at count 3.
      idle(); INCFIFO = 1'b1;
      repeat (3) step();
      DECFIFO = 1'b1; step();
      chk("incdec_CNT", 32'(FIFOCNT), 32'd3);
      flush();

      // S2F and LW_WR together: longword wins.
      idle(); S2F = 1'b1; LW_WR = 1'b1; SCSI_DIN = 8'hEE; BUS_DIN = 32'h12345678;
      step();
      chk("lw_wins", BUS_DOUT, 32'h12345678);

      // Flush mid-transfer: set NI=5, NO=2, BO=2, count 3, UNF set.
      flush();
      idle(); DECFIFO = 1'b1; step();
      for (int k = 0; k < 5; k++) begin
         idle(); LW_WR = 1'b1; BUS_DIN = 32'hC0DE0000 + 32'(k); INCNI = 1'b1;
         INCFIFO = (k < 3); INCNO = (k < 2); INCBO = (k < 2);
         step();
      end
      chk("pre_NI", 32'(NI), 32'd5);
      chk("pre_NO", 32'(NO), 32'd2);
      chk("pre_BO", 32'(BO), 32'd2);
      chk("pre_CNT", 32'(FIFOCNT), 32'd3);
      RESET_ = 1'b1; FIFO_CLR = 1'b1; INCFIFO = 1'b1; DECFIFO = 1'b1;
      INCNI = 1'b1; INCNO = 1'b1; INCBO = 1'b1; S2F = 1'b1; LW_WR = 1'b1;
      BUS_DIN = 32'hFFFFFFFF;
      step();
      chk("fl_NI", 32'(NI), 32'd0);
      chk("fl_NO", 32'(NO), 32'd0);
      chk("fl_BO", 32'(BO), 32'd0);
      chk("fl_CNT", 32'(FIFOCNT), 32'd0);
      chk("fl_UNF", 32'(UNF), 32'd0);
      chk("fl_OVF", 32'(OVF), 32'd0);
      chk("fl_entry0", BUS_DOUT, 32'hC0DE0000);
      for (int k = 1; k < 5; k++) begin
         idle(); INCNO = 1'b1; step();
         chk("fl_entry", BUS_DOUT, 32'hC0DE0000 + 32'(k));
      end

      // Randomized strobes with occasional flush and reset.
      for (int n = 0; n < 3000; n++) begin
         RESET_   = ($urandom_range(0, 199) != 0);
         FIFO_CLR = ($urandom_range(0, 31) == 0);
         INCFIFO  = 1'($urandom_range(0, 1));
         DECFIFO  = 1'($urandom_range(0, 1));
         INCNI    = 1'($urandom_range(0, 1));
         INCNO    = 1'($urandom_range(0, 1));
         INCBO    = 1'($urandom_range(0, 1));
         S2F      = 1'($urandom_range(0, 1));
         LW_WR    = ($urandom_range(0, 3) == 0);
         SCSI_DIN = 8'($urandom);
         BUS_DIN  = $urandom;
         step();
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdmac_fifo.md
Name: sdmac_fifo

Overview:
Longword FIFO between the SCSI state machine and the DMA bus side of the SDMAC. It holds 8 x 32-bit entries. The SCSI side accesses entries one byte lane at a time through a 2-bit byte pointer (BO); the bus side accesses whole longwords.
All pointer and count movement is commanded by strobes from the SCSI state machine and DMA control: INCBO, INCNI, INCNO, INCFIFO and DECFIFO. The block returns FIFOFULL, FIFOEMPTY and BOEQ3 to them.

Parameters:
DEPTH_LOG2, 3, log2 of entry count; depth = 2**DEPTH_LOG2 = 8. Count width is DEPTH_LOG2+1.

Ports:
CPUCLK  in  1  system clock; all state changes on rising edge
RESET_  in  1  synchronous active-low reset, sampled on rising CPUCLK
FIFO_CLR  in  1  synchronous flush of pointers, count and error flags; storage untouched
INCFIFO  in  1  increment longword count, once per cycle high
DECFIFO  in  1  decrement longword count, once per cycle high
INCNI  in  1  advance next-in pointer NI, once per cycle high
INCNO  in  1  advance next-out pointer NO, once per cycle high
INCBO  in  1  advance byte pointer BO, once per cycle high
S2F  in  1  write SCSI_DIN into byte lane BO of entry NI
LW_WR  in  1  write BUS_DIN (all 32 bits) into entry NI
SCSI_DIN  in  8  byte from SCSI controller
BUS_DIN  in  32  longword from CPU/DMA data bus
BUS_DOUT  out  32  entry NO (combinational read of storage)
SCSI_DOUT  out  8  byte lane BO of entry NO (combinational)
BO  out  2  byte pointer
NI  out  3  next-in pointer
NO  out  3  next-out pointer
FIFOCNT  out  4  longwords held, 0..8
FIFOFULL  out  1  FIFOCNT == 8
FIFOEMPTY  out  1  FIFOCNT == 0
BOEQ3  out  1  BO == 3
OVF  out  1  sticky: INCFIFO seen while full
UNF  out  1  sticky: DECFIFO seen while empty

Behaviour:
- Clock and reset: one clock (CPUCLK). Reset is synchronous and active-low (RESET_).
- Reset (RESET_=0 at rising edge): BO=0, NI=0, NO=0, FIFOCNT=0, OVF=0, UNF=0, all 8 storage words=0. Resulting outputs: FIFOEMPTY=1, FIFOFULL=0, BOEQ3=0, BUS_DOUT=0, SCSI_DOUT=0. Reset overrides every strobe in the same cycle, including reset asserted mid-transfer.
- FIFO_CLR (RESET_=1): same as reset except storage keeps its contents. It overrides all other strobes that cycle.
- Strobes are level-sampled. Each cycle a strobe is high produces exactly one step. There is no edge detection.
- Byte lane order is big-endian (68k): BO=0 -> bits[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
- S2F writes only the selected lane; the other three lanes of entry NI are preserved.
- LW_WR writes the whole entry NI. If S2F and LW_WR are both high, LW_WR wins and S2F is ignored.
- Same-cycle ordering: a write uses the pre-edge NI and BO; INCNI and INCBO take effect after the write.
- Reads also use the current pointers, so NO and BO advance after a combinational read is consumed.
- Pointer arithmetic:
  - BO increments modulo 4; 3 -> 0 with no side effect on NI or NO. The state machine issues INCNI/INCNO itself.
  - NI and NO increment modulo 8.
- Count rules:
  - INCFIFO and DECFIFO together: FIFOCNT unchanged.
  - INCFIFO alone at 8: FIFOCNT stays 8, OVF set.
  - DECFIFO alone at 0: FIFOCNT stays 0, UNF set.
  - Otherwise FIFOCNT +1 or -1.
- Pointers are not gated by the count. The controller guarantees consistency; OVF/UNF flag misuse of the count only.
- FIFOFULL, FIFOEMPTY and BOEQ3 are decoded combinationally from the registered count and BO. There is zero cycle latency from the register update.
- Read latency: BUS_DOUT and SCSI_DOUT reflect a write on the cycle after the writing edge.

Test Plan:
- Reset: RESET_ low 2 cycles with all strobes high -> BO=0, NI=0, NO=0, FIFOCNT=0, FIFOEMPTY=1, FIFOFULL=0, BOEQ3=0, BUS_DOUT=0.
- SCSI-to-FIFO packing: 32 cycles of S2F+INCBO with SCSI_DIN=0x00..0x1F. Assert INCNI and INCFIFO on each cycle where BOEQ3=1.
  -> Entry 0=0x00010203 … entry 7=0x1C1D1E1F. NI wraps to 0, FIFOCNT=8, FIFOFULL=1, BO=0.
- Drain to bus: from full, 8 cycles of INCNO+DECFIFO -> BUS_DOUT sequence 0x00010203..0x1C1D1E1F, final FIFOCNT=0, FIFOEMPTY=1, NO=0, UNF=0.
- Bus-to-SCSI: LW_WR with BUS_DIN=0xA1B2C3D4 plus INCNI+INCFIFO.
  -> Then 4 cycles of INCBO: SCSI_DOUT = 0xA1, 0xB2, 0xC3, 0xD4. BOEQ3 is high only on the fourth; BO returns to 0.
- Boundaries:
  - INCFIFO at count 8 -> count stays 8, OVF=1.
  - DECFIFO at count 0 -> UNF=1.
  - INCFIFO+DECFIFO at count 3 -> count stays 3.
  - S2F+LW_WR together -> full-word BUS_DIN is stored.
- Flush mid-transfer: with NI=5, NO=2, BO=2, FIFOCNT=3, pulse FIFO_CLR -> pointers and count 0, OVF=UNF=0, storage contents still readable at the old entries.
